fpu_norm_shifter: RTL and testbench

Multi-cycle normalization shifter for the FMADD datapath. It consumes the unnormalized mantissa together with the leading-zero count produced by the LZD tree. It left-shifts the mantissa by that count, one binary shift stage per cycle, and adjusts the biased exponent. The result is clamped to the denormal range when the count would drive the exponent to or below zero. The block sits between the LZD tree and the rounding stage, with valid/ready handshakes on both sides.

---
 rtl/fpu_norm_shifter.sv | 134 +++++++++++++
 tb/tb_fpu_norm_shifter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_norm_shifter.sv
// Normalization shifter for the FMADD datapath: left-shifts the mantissa by the LZD count
// one binary stage per cycle, adjusts the biased exponent and clamps into the denormal range.
module fpu_norm_shifter #(
    parameter int MAN_W = 24,
    parameter int EXP_W = 8,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [MAN_W-1:0] in_man,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [CNT_W-1:0] in_lz_cnt,
    input  logic             in_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAN_W-1:0] out_man,
    output logic [EXP_W-1:0] out_exp,
    output logic             out_zero,
    output logic             out_denorm
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    // Wide enough to compare the count against the exponent without truncating either.
    localparam int CMP_W = ((EXP_W > CNT_W) ? EXP_W : CNT_W) + 1;
    localparam logic [CMP_W-1:0] MAX_SHIFT = CMP_W'(MAN_W - 1);

    logic [1:0]       state_reg;
    logic [MAN_W-1:0] man_reg;
    logic [EXP_W-1:0] exp_reg;
    logic             zero_reg;
    logic             denorm_reg;
    logic [CNT_W-1:0] eff_reg;
    logic [CNT_W-1:0] k_reg;

    logic [CMP_W-1:0] lz_ext;
    logic [CMP_W-1:0] exp_ext;
    logic             lz_below_exp;
    logic [CMP_W-1:0] raw_shift;
    logic [CMP_W-1:0] clamped_shift;
    logic [CNT_W-1:0] eff_next;
    logic [EXP_W-1:0] exp_next;
    logic             denorm_next;

    assign lz_ext       = CMP_W'(in_lz_cnt);
    assign exp_ext      = CMP_W'(in_exp);
    assign lz_below_exp = lz_ext < exp_ext;

    // When the count reaches the exponent, shift only far enough to land on exponent 1,
    // which the denormal encoding represents as exponent 0.
    always_comb begin
        raw_shift = '0;
        if (in_zero) begin
            raw_shift = '0;
        end else if (lz_below_exp) begin
            raw_shift = lz_ext;
        end else if (exp_ext != '0) begin
            raw_shift = exp_ext - CMP_W'(1);
        end
        clamped_shift = (raw_shift > MAX_SHIFT) ? MAX_SHIFT : raw_shift;
    end

    assign eff_next    = CNT_W'(clamped_shift);
    assign exp_next    = (!in_zero && lz_below_exp) ? (in_exp - EXP_W'(in_lz_cnt)) : '0;
    assign denorm_next = !in_zero && !lz_below_exp;

    // One candidate per binary stage; stages at or beyond the mantissa width clear it.
    logic [MAN_W-1:0] stage_shift [CNT_W];

    generate
        for (genvar gi = 0; gi < CNT_W; gi++) begin : g_stage
            localparam int AMT = 1 << gi;
            if (AMT < MAN_W) begin : g_part
                assign stage_shift[gi] = {man_reg[MAN_W-1-AMT:0], {AMT{1'b0}}};
            end else begin : g_full
                assign stage_shift[gi] = '0;
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            man_reg    <= '0;
            exp_reg    <= '0;
            zero_reg   <= 1'b0;
            denorm_reg <= 1'b0;
            eff_reg    <= '0;
            k_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        man_reg    <= in_man;
                        exp_reg    <= exp_next;
                        zero_reg   <= in_zero;
                        denorm_reg <= denorm_next;
                        eff_reg    <= eff_next;
                        k_reg      <= CNT_W'(CNT_W - 1);
                        state_reg  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (eff_reg[k_reg]) begin
                        man_reg <= stage_shift[k_reg];
                    end
                    if (k_reg == '0) begin
                        state_reg <= DONE;
                    end else begin
                        k_reg <= k_reg - CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_reg == IDLE) && !rst;
    assign out_valid  = (state_reg == DONE);
    assign out_man    = man_reg;
    assign out_exp    = exp_reg;
    assign out_zero   = zero_reg;
    assign out_denorm = denorm_reg;

endmodule

// File: tb/tb_fpu_norm_shifter.sv
// Bench for fpu_norm_shifter: directed and random operands checked against an arithmetic
// model of the normalization rules, plus latency, backpressure, throughput and reset abort.
module tb_fpu_norm_shifter;

    localparam int MAN_W = 24;
    localparam int EXP_W = 8;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [MAN_W-1:0] in_man = '0;
    logic [EXP_W-1:0] in_exp = '0;
    logic [CNT_W-1:0] in_lz_cnt = '0;
    logic             in_zero = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [MAN_W-1:0] out_man;
    logic [EXP_W-1:0] out_exp;
    logic             out_zero;
    logic             out_denorm;

    int n_cmp = 0;
    int n_fail = 0;

    fpu_norm_shifter #(.MAN_W(MAN_W), .EXP_W(EXP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_man(in_man), .in_exp(in_exp), .in_lz_cnt(in_lz_cnt), .in_zero(in_zero),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_man(out_man), .out_exp(out_exp), .out_zero(out_zero), .out_denorm(out_denorm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    // Normalization rules stated arithmetically: multiply by 2^shift and truncate.
    task automatic model(input logic [MAN_W-1:0] man, input int e, input int lz, input bit z,
                         output logic [MAN_W-1:0] om, output int oe, output bit oz, output bit od);
        int    sh;
        longint prod;
        if (z)           sh = 0;
        else if (lz < e) sh = lz;
        else             sh = (e == 0) ? 0 : e - 1;
        if (sh > MAN_W - 1) sh = MAN_W - 1;
        prod = longint'(man) * (longint'(1) << sh);
        om = prod[MAN_W-1:0];
        oe = (!z && lz < e) ? e - lz : 0;
        oz = z;
        od = !z && (lz >= e);
    endtask

    function automatic int lead_zeros(input logic [MAN_W-1:0] m);
        for (int i = MAN_W - 1; i >= 0; i--) begin
            if (m[i]) return MAN_W - 1 - i;
        end
        return MAN_W;
    endfunction

    // One operand through the block; hold > 0 keeps out_ready low for that many cycles of DONE.
    task automatic run_op(input string tag, input logic [MAN_W-1:0] man, input int e,
                          input int lz, input bit z, input int hold);
        logic [MAN_W-1:0] em;
        int ee;
        bit ez, ed;
        int cyc;
        model(man, e, lz, z, em, ee, ez, ed);
        @(negedge clk);
        in_man = man; in_exp = EXP_W'(e); in_lz_cnt = CNT_W'(lz); in_zero = z;
        in_valid = 1'b1;
        out_ready = (hold == 0);
        chk({tag, " in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, 32'(cyc), 32'(CNT_W + 1));
        chk({tag, " man"}, 32'(out_man), 32'(em));
        chk({tag, " exp"}, 32'(out_exp), 32'(ee));
        chk({tag, " zero"}, 32'(out_zero), 32'(ez));
        chk({tag, " denorm"}, 32'(out_denorm), 32'(ed));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; in_man = ~man; in_exp = EXP_W'(e + 1); in_lz_cnt = '0; in_zero = 1'b0;
            @(posedge clk); #1;
            chk({tag, " hold_valid"}, 32'(out_valid), 32'd1);
            chk({tag, " hold_in_ready"}, 32'(in_ready), 32'd0);
            chk({tag, " hold_man"}, 32'(out_man), 32'(em));
            chk({tag, " hold_exp"}, 32'(out_exp), 32'(ee));
            chk({tag, " hold_denorm"}, 32'(out_denorm), 32'(ed));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, " after_hs_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " after_hs_in_ready"}, 32'(in_ready), 32'd1);
        $display("txn %s: man=%h exp=%h lz=%0d zero=%0d -> man=%h exp=%h zero=%0d denorm=%0d",
                 tag, man, e[7:0], lz, z, out_man, out_exp, out_zero, out_denorm);
    endtask

    initial begin
        logic [MAN_W-1:0] rm;
        int re, rl, seen;
        logic [MAN_W-1:0] bm [6];
        int be [6];
        int bl [6];
        bit bz [6];
        int q [$];
        int sent, got, cyc, last_cyc;
        logic [MAN_W-1:0] em;
        int ee;
        bit ez, ed;

        // Reset state
        @(posedge clk); #1;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_man", 32'(out_man), 32'd0);
        chk("rst out_exp", 32'(out_exp), 32'd0);
        chk("rst flags", {30'd0, out_zero, out_denorm}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("release in_ready", 32'(in_ready), 32'd1);

        // Directed cases
        run_op("normal", 24'h000400, 8'h80, 13, 1'b0, 0);
        run_op("denorm", 24'h000400, 8'h05, 13, 1'b0, 0);
        run_op("zero", 24'h000000, 8'h40, 24, 1'b1, 0);
        run_op("noshift", 24'h800000, 8'h7F, 0, 1'b0, 0);
        run_op("exp0", 24'h000010, 8'h00, 19, 1'b0, 0);
        run_op("exp_eq_lz", 24'h000100, 8'd15, 15, 1'b0, 0);
        run_op("lz_clamp", 24'h000001, 8'd200, 31, 1'b0, 0);
        run_op("backpressure", 24'h012345, 8'h90, 7, 1'b0, 3);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("bp no phantom op", 32'(seen), 32'd0);

        // Random single operands
        for (int n = 0; n < 12; n++) begin
            rm = MAN_W'($urandom) >> $urandom_range(0, MAN_W);
            re = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 30) : $urandom_range(0, 255);
            rl = lead_zeros(rm);
            run_op($sformatf("rand%0d", n), rm, re, rl, rm == '0, $urandom_range(0, 2));
        end

        // Back-to-back with out_ready high: in order, one result every CNT_W+2 cycles
        for (int i = 0; i < 6; i++) begin
            bm[i] = MAN_W'($urandom) >> $urandom_range(0, MAN_W - 1);
            be[i] = $urandom_range(0, 255);
            bl[i] = lead_zeros(bm[i]);
            bz[i] = (bm[i] == '0);
        end
        out_ready = 1'b1;
        sent = 0; got = 0; cyc = 0; last_cyc = -1;
        while (got < 6 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("b2b unexpected result", 32'd1, 32'd0);
                end else begin
                    model(bm[q[0]], be[q[0]], bl[q[0]], bz[q[0]], em, ee, ez, ed);
                    chk($sformatf("b2b%0d man", q[0]), 32'(out_man), 32'(em));
                    chk($sformatf("b2b%0d exp", q[0]), 32'(out_exp), 32'(ee));
                    chk($sformatf("b2b%0d flags", q[0]), {30'd0, out_zero, out_denorm}, {30'd0, ez, ed});
                    if (last_cyc >= 0) chk($sformatf("b2b%0d spacing", q[0]), 32'(cyc - last_cyc), 32'(CNT_W + 2));
                    $display("txn b2b%0d: man=%h exp=%h -> man=%h exp=%h", q[0], bm[q[0]], be[q[0]], out_man, out_exp);
                    last_cyc = cyc;
                    void'(q.pop_front());
                    got++;
                end
            end
            if (sent < 6) begin
                in_man = bm[sent]; in_exp = EXP_W'(be[sent]); in_lz_cnt = CNT_W'(bl[sent]);
                in_zero = bz[sent]; in_valid = 1'b1;
                if (in_ready) begin
                    q.push_back(sent);
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
            end
        end
        in_valid = 1'b0;
        chk("b2b result count", 32'(got), 32'd6);

        // Reset during the third SHIFT cycle
        @(negedge clk);
        in_man = 24'h000400; in_exp = 8'h80; in_lz_cnt = 5'd13; in_zero = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort pre valid", 32'(out_valid), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort in_ready", 32'(in_ready), 32'd0);
        chk("abort out_man", 32'(out_man), 32'd0);
        chk("abort out_exp", 32'(out_exp), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort release in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort no result", 32'(seen), 32'd0);
        run_op("after_abort", 24'h000400, 8'h80, 13, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
